// File: rtl/trap_ctrl.sv
// Trap sequencer: owns the CSR unit's single access port. Writes mepc/mcause/
// mtval and reads mtvec on an exception, reads mepc on mret, then emits a
// one-cycle redirect. While idle the core's CSR accesses pass straight through.
module trap_ctrl #(
  parameter logic [31:0] MTVEC_ADDR  = 32'h305,
  parameter logic [31:0] MEPC_ADDR   = 32'h341,
  parameter logic [31:0] MCAUSE_ADDR = 32'h342,
  parameter logic [31:0] MTVAL_ADDR  = 32'h343
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        exc_valid,
  input  logic [31:0] exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic [31:0] core_csr_addr,
  input  logic [31:0] core_csr_din,
  input  logic        core_csr_we,
  output logic [31:0] core_csr_dout,
  output logic [31:0] csr_address,
  output logic [31:0] csr_din,
  output logic        csr_we,
  input  logic [31:0] csr_dout,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        trap_lost
);

  typedef enum logic [2:0] {
    IDLE, W_EPC, W_CAUSE, W_TVAL, RD_TVEC, RD_EPC, REDIRECT
  } state_t;

  state_t      state, state_next;
  logic [31:0] cap_pc, cap_cause, cap_tval;

  // State register, captured trap fields, redirect target and lost-request flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cap_pc      <= '0;
      cap_cause   <= '0;
      cap_tval    <= '0;
      redirect_pc <= '0;
      trap_lost   <= 1'b0;
    end else begin
      state     <= state_next;
      trap_lost <= (state != IDLE) && (exc_valid || mret_valid);
      if (state == IDLE && exc_valid) begin
        cap_pc    <= exc_pc;
        cap_cause <= exc_cause;
        cap_tval  <= exc_tval;
      end
      // Handler targets are word-aligned: drop the low two bits of the read
      if (state == RD_TVEC || state == RD_EPC)
        redirect_pc <= csr_dout & ~32'h3;
    end
  end

  // Next-state selection and CSR port muxing
  always_comb begin
    state_next     = state;
    csr_address    = '0;
    csr_din        = '0;
    csr_we         = 1'b0;
    core_csr_dout  = '0;
    busy           = 1'b1;
    redirect_valid = 1'b0;
    case (state)
      IDLE: begin
        busy          = 1'b0;
        csr_address   = core_csr_addr;
        csr_din       = core_csr_din;
        csr_we        = core_csr_we;
        core_csr_dout = csr_dout;
        if (exc_valid)       state_next = W_EPC;
        else if (mret_valid) state_next = RD_EPC;
      end
      W_EPC: begin
        csr_address = MEPC_ADDR;
        csr_din     = cap_pc;
        csr_we      = 1'b1;
        state_next  = W_CAUSE;
      end
      W_CAUSE: begin
        csr_address = MCAUSE_ADDR;
        csr_din     = cap_cause;
        csr_we      = 1'b1;
        state_next  = W_TVAL;
      end
      W_TVAL: begin
        csr_address = MTVAL_ADDR;
        csr_din     = cap_tval;
        csr_we      = 1'b1;
        state_next  = RD_TVEC;
      end
      RD_TVEC: begin
        csr_address = MTVEC_ADDR;
        state_next  = REDIRECT;
      end
      RD_EPC: begin
        csr_address = MEPC_ADDR;
        state_next  = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
